// File: rtl/ysyx_25040111_rd_arbiter.sv
// ysyx_25040111_rd_arbiter: round-robin IFU/LSU read arbiter routing a single outstanding read to CLINT or memory.
module ysyx_25040111_rd_arbiter #(
  parameter logic [31:0] CLINT_LO = 32'ha000_0048,
  parameter logic [31:0] CLINT_HI = 32'ha000_004f
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] s0_araddr,
  output logic        s0_arvalid,
  input  logic        s0_arready,
  input  logic [31:0] s0_rdata,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  output logic [31:0] s1_araddr,
  output logic        s1_arvalid,
  input  logic        s1_arready,
  input  logic [31:0] s1_rdata,
  input  logic        s1_rvalid,
  output logic        s1_rready
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t      r_state, w_next;
  logic        r_owner, r_last, r_sel;
  logic [31:0] r_addr;
  logic        w_st_idle, w_st_addr, w_st_data;
  logic        w_req, w_gnt, w_hit, w_ar_hs, w_rv, w_rr;
  logic [31:0] w_req_addr, w_rd;
  // Outputs are gated by reset so the reset cycle itself already shows quiet buses.
  assign w_st_idle  = (r_state == IDLE) && !reset;
  assign w_st_addr  = (r_state == ADDR) && !reset;
  assign w_st_data  = (r_state == DATA) && !reset;
  assign w_req      = m0_arvalid | m1_arvalid;
  assign w_gnt      = (m0_arvalid & m1_arvalid) ? ~r_last : m1_arvalid;
  assign w_req_addr = w_gnt ? m1_araddr : m0_araddr;
  assign w_hit      = (w_req_addr >= CLINT_LO) && (w_req_addr <= CLINT_HI);
  assign w_ar_hs    = r_sel ? s1_arready : s0_arready;
  assign w_rv       = r_sel ? s1_rvalid : s0_rvalid;
  assign w_rd       = r_sel ? s1_rdata : s0_rdata;
  assign w_rr       = r_owner ? m1_rready : m0_rready;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_req ? ADDR : IDLE;
      ADDR:    w_next = w_ar_hs ? DATA : ADDR;
      DATA:    w_next = (w_rv && w_rr) ? IDLE : DATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // last_grant starts at m1 so m0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
      r_addr  <= '0;
    end else if (r_state == IDLE && w_req) begin
      r_owner <= w_gnt;
      r_last  <= w_gnt;
      r_sel   <= ~w_hit;
      r_addr  <= w_req_addr;
    end
  end
  assign m0_arready = w_st_idle & w_req & ~w_gnt;
  assign m1_arready = w_st_idle & w_req & w_gnt;
  assign m0_rvalid  = w_st_data & ~r_owner & w_rv;
  assign m1_rvalid  = w_st_data & r_owner & w_rv;
  assign m0_rdata   = (w_st_data & ~r_owner) ? w_rd : '0;
  assign m1_rdata   = (w_st_data & r_owner) ? w_rd : '0;
  assign s0_arvalid = w_st_addr & ~r_sel;
  assign s1_arvalid = w_st_addr & r_sel;
  assign s0_araddr  = (w_st_addr & ~r_sel) ? r_addr : '0;
  assign s1_araddr  = (w_st_addr & r_sel) ? r_addr : '0;
  assign s0_rready  = w_st_data & ~r_sel & w_rr;
  assign s1_rready  = w_st_data & r_sel & w_rr;
endmodule

// File: tb/tb_ysyx_25040111_rd_arbiter.sv
// tb_ysyx_25040111_rd_arbiter: directed reads with a response scoreboard for the read arbiter.
module tb_ysyx_25040111_rd_arbiter;
  localparam logic [63:0] MTIME = 64'h0000_0005_0000_0123;
  logic        clock, reset;
  logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] s0_araddr, s0_rdata, s1_araddr, s1_rdata;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic        s0_pend, s1_pend, s1_blk, s0_spur;
  logic [31:0] s0_paddr, s1_paddr;
  typedef struct {int m; logic [31:0] d;} exp_t;
  exp_t        sb[$];
  int          n_vec = 0, n_err = 0, cyc = 0, s0_ar_cnt = 0, s0_rr_cnt = 0;
  int          g_order[$], g_cyc[$];
  logic [31:0] c_addr [2][4] = '{'{32'h8000_1000, 32'h8000_1004, 32'ha000_0048, 32'h8000_1008},
                                 '{32'h8000_2000, 32'ha000_004c, 32'h8000_2004, 32'h8000_2008}};
  logic [31:0] c_exp  [2][4] = '{'{32'h1000_beef, 32'h1004_beef, 32'h0000_0123, 32'h1008_beef},
                                 '{32'h2000_beef, 32'h0000_0005, 32'h2004_beef, 32'h2008_beef}};

  ysyx_25040111_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // CLINT returns the mtime half picked by addr[2]; memory returns {addr[15:0], 16'hbeef} except 0x80000000.
  assign s0_arready = ~s0_pend;
  assign s0_rvalid  = s0_pend | s0_spur;
  assign s0_rdata   = s0_paddr[2] ? MTIME[63:32] : MTIME[31:0];
  assign s1_arready = ~s1_pend & ~s1_blk;
  assign s1_rvalid  = s1_pend;
  assign s1_rdata   = !s1_pend ? 32'h0 : (s1_paddr == 32'h8000_0000) ? 32'hdead_beef : {s1_paddr[15:0], 16'hbeef};
  always @(posedge clock) begin
    if (reset) begin
      s0_pend <= 1'b0; s0_paddr <= '0; s1_pend <= 1'b0; s1_paddr <= '0;
    end else begin
      if (s0_arvalid && s0_arready) begin s0_pend <= 1'b1; s0_paddr <= s0_araddr; end
      else if (s0_pend && s0_rready) s0_pend <= 1'b0;
      if (s1_arvalid && s1_arready) begin s1_pend <= 1'b1; s1_paddr <= s1_araddr; end
      else if (s1_pend && s1_rready) s1_pend <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_rsp(input int m, input logic [31:0] d, input logic orv, input logic [31:0] od);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL rsp_unexpected: master %0d got %h expected no response", m, d);
    end else begin
      e = sb.pop_front();
      chk("rsp_master", 32'(m), 32'(e.m));
      chk("rsp_data", d, e.d);
      chk("nonowner_rvalid", 32'(orv), 32'd0);
      chk("nonowner_rdata", od, 32'd0);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (m0_rvalid && m0_rready) check_rsp(0, m0_rdata, m1_rvalid, m1_rdata);
      if (m1_rvalid && m1_rready) check_rsp(1, m1_rdata, m0_rvalid, m0_rdata);
    end
    if (s0_arvalid) s0_ar_cnt <= s0_ar_cnt + 1;
    if (s0_rready) s0_rr_cnt <= s0_rr_cnt + 1;
  end

  task automatic set_m(input int m, input logic v, input logic [31:0] a);
    if (m == 0) begin m0_arvalid = v; m0_araddr = a; end
    else begin m1_arvalid = v; m1_araddr = a; end
  endtask

  task automatic wait_gnt(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (m == 0 ? m0_arready : m1_arready) begin ok = 1'b1; return; end
    end
    n_vec++; n_err++;
    $display("FAIL grant_timeout: master %0d saw no arready, expected one within 64 cycles", m);
  endtask

  task automatic wait_rv(input int m);
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (m == 0 ? m0_rvalid : m1_rvalid) return;
    end
    n_vec++; n_err++;
    $display("FAIL rvalid_timeout: master %0d saw no rvalid, expected one within 64 cycles", m);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) return;
      @(negedge clock);
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    @(posedge clock); #1;
    set_m(m, 1'b1, a);
    wait_gnt(m, ok);
    if (ok) sb.push_back(exp_t'{m, d});
    @(posedge clock); #1;
    set_m(m, 1'b0, 32'h0);
  endtask

  task automatic rd(input int m, input logic [31:0] a, input logic [31:0] d);
    issue(m, a, d);
    drain();
  endtask

  task automatic contend(input int m);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      set_m(m, 1'b1, c_addr[m][k]);
      wait_gnt(m, ok);
      if (!ok) return;
      g_order.push_back(m);
      g_cyc.push_back(cyc);
      sb.push_back(exp_t'{m, c_exp[m][k]});
      @(posedge clock); #1;
      set_m(m, 1'b0, 32'h0);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 32'({m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                           s0_arvalid, s1_arvalid, s0_rready, s1_rready}), 32'd0);
    chk({nm, "_data"}, m0_rdata | m1_rdata | s0_araddr | s1_araddr, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int c0, r0;
    bit ok;
    reset = 1'b1; s1_blk = 1'b0; s0_spur = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_araddr = '0; m1_araddr = '0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    repeat (2) @(negedge clock);
    chk_zero("reset_state");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk_zero("idle_after_reset");

    // CLINT read with exact cycle-by-cycle latency, then a grant to m1 at N+3.
    @(posedge clock); #1;
    set_m(0, 1'b1, 32'ha000_0048);
    @(negedge clock);
    chk("t1_m0_arready_N", 32'(m0_arready), 32'd1);
    chk("t1_m1_arready_N", 32'(m1_arready), 32'd0);
    sb.push_back(exp_t'{0, 32'h0000_0123});
    @(posedge clock); #1;
    set_m(0, 1'b0, 32'h0);
    @(negedge clock);
    chk("t1_s0_arvalid_N1", 32'(s0_arvalid), 32'd1);
    chk("t1_s0_araddr_N1", s0_araddr, 32'ha000_0048);
    chk("t1_s1_arvalid_N1", 32'(s1_arvalid), 32'd0);
    @(posedge clock); #1;
    set_m(1, 1'b1, 32'h8000_0100);
    @(negedge clock);
    chk("t1_m0_rvalid_N2", 32'(m0_rvalid), 32'd1);
    chk("t1_m1_arready_N2", 32'(m1_arready), 32'd0);
    @(negedge clock);
    chk("t1_m1_arready_N3", 32'(m1_arready), 32'd1);
    sb.push_back(exp_t'{1, 32'h0100_beef});
    @(posedge clock); #1;
    set_m(1, 1'b0, 32'h0);
    drain();
    rd(0, 32'ha000_004c, 32'h0000_0005);
    rd(0, 32'ha000_004f, 32'h0000_0005);
    rd(1, 32'ha000_0047, 32'h0047_beef);

    // Memory-routed reads with a spurious CLINT rvalid that must never be forwarded.
    c0 = s0_ar_cnt; r0 = s0_rr_cnt;
    s0_spur = 1'b1;
    @(negedge clock);
    chk("t3_spur_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("t3_spur_m0_rdata", m0_rdata, 32'd0);
    chk("t3_spur_s0_rready", 32'(s0_rready), 32'd0);
    rd(1, 32'h8000_0000, 32'hdead_beef);
    rd(1, 32'ha000_0050, 32'h0050_beef);
    s0_spur = 1'b0;
    @(negedge clock);
    chk("t3_s0_arvalid_cycles", 32'(s0_ar_cnt - c0), 32'd0);
    chk("t3_s0_rready_cycles", 32'(s0_rr_cnt - r0), 32'd0);

    // Contention straight after reset: m0 first, strict alternation.
    do_reset();
    fork
      contend(0);
      contend(1);
    join
    drain();
    chk("t2_grants", 32'(g_order.size()), 32'd8);
    for (int i = 0; i < g_order.size(); i++) chk("t2_order", 32'(g_order[i]), 32'(i % 2));
    if (g_cyc.size() >= 2) chk("t2_m1_grant_N3", 32'(g_cyc[1] - g_cyc[0]), 32'd3);

    // Address stall then response backpressure while m0 keeps requesting.
    s1_blk = 1'b1;
    @(posedge clock); #1;
    set_m(1, 1'b1, 32'h8000_0000);
    wait_gnt(1, ok);
    if (ok) sb.push_back(exp_t'{1, 32'hdead_beef});
    @(posedge clock); #1;
    set_m(1, 1'b0, 32'h0);
    set_m(0, 1'b1, 32'h8000_0100);
    repeat (5) begin
      @(negedge clock);
      chk("t4_stall_s1_arvalid", 32'(s1_arvalid), 32'd1);
      chk("t4_stall_s1_araddr", s1_araddr, 32'h8000_0000);
      chk("t4_stall_m0_arready", 32'(m0_arready), 32'd0);
    end
    m1_rready = 1'b0;
    @(posedge clock); #1;
    s1_blk = 1'b0;
    wait_rv(1);
    repeat (3) begin
      @(negedge clock);
      chk("t4_hold_m1_rvalid", 32'(m1_rvalid), 32'd1);
      chk("t4_hold_m1_rdata", m1_rdata, 32'hdead_beef);
      chk("t4_hold_s1_rready", 32'(s1_rready), 32'd0);
      chk("t4_hold_m0_arready", 32'(m0_arready), 32'd0);
    end
    @(posedge clock); #1;
    m1_rready = 1'b1;
    wait_gnt(0, ok);
    if (ok) sb.push_back(exp_t'{0, 32'h0100_beef});
    @(posedge clock); #1;
    set_m(0, 1'b0, 32'h0);
    drain();

    // Reset in ADDR, then in DATA, then a normal read.
    s1_blk = 1'b1;
    issue(0, 32'h8000_0000, 32'hdead_beef);
    @(negedge clock);
    chk("t5_in_addr", 32'(s1_arvalid), 32'd1);
    do_reset();
    s1_blk = 1'b0;
    @(negedge clock);
    chk_zero("t5_after_addr_reset");
    m0_rready = 1'b0;
    issue(0, 32'ha000_0048, 32'h0000_0123);
    wait_rv(0);
    do_reset();
    m0_rready = 1'b1;
    @(negedge clock);
    chk_zero("t5_after_data_reset");
    rd(0, 32'ha000_004c, 32'h0000_0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
